// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkg : shared FSM encoding and default sizing for the arbiter |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package router_pkg;

  localparam int N_PORTS_DEF = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick  : combinational rotating-priority picker, search from ptr  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [SW-1:0] o_idx,
  output logic          o_any
);

  localparam int SW1 = SW + 1;

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int i = 0; i < N; i++) begin
      // Candidate index (ptr + i) mod N, kept narrow so it can index i_req directly.
      w_sum = {1'b0, i_ptr} + SW1'(i);
      if (w_sum >= SW1'(N)) begin
        w_sum = w_sum - SW1'(N);
      end
      w_pos = w_sum[SW-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_arbiter : round-robin grant of N input buffers onto one link |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module output_arbiter
  import router_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_PORTS-1:0]         isfull,
  input  logic                       out_ready,
  output logic [N_PORTS-1:0]         chosen_one,
  output logic                       read_en,
  output logic [N_PORTS-1:0]         clearflag,
  output logic [$clog2(N_PORTS)-1:0] sel,
  output logic                       valid_out,
  output logic                       timeout_err
);

  localparam int SEL_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_PORTS-1:0] r_chosen;
  logic [SEL_W-1:0]   r_sel;
  logic               r_read_en;
  logic [N_PORTS-1:0] r_clear;
  logic               r_valid;
  logic               r_tmo;

  logic [N_PORTS-1:0] w_grant;
  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic [SEL_W-1:0]   w_ptr_next;

  rr_pick #(
    .N  (N_PORTS),
    .SW (SEL_W)
  ) u_pick (
    .i_req   (isfull),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_next = (r_sel == SEL_W'(N_PORTS - 1)) ? '0 : r_sel + SEL_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_chosen  <= '0;
      r_sel     <= '0;
      r_read_en <= 1'b0;
      r_clear   <= '0;
      r_valid   <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_clear   <= '0;
      r_tmo     <= 1'b0;
      r_read_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state   <= ST_GRANT;
            r_chosen  <= w_grant;
            r_sel     <= w_idx;
            r_read_en <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!isfull[r_sel]) begin
            r_state  <= ST_IDLE;
            r_chosen <= '0;
            r_sel    <= '0;
          end else begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_SEND: begin
          // A vanished buffer wins over both a transfer and a timeout.
          if (!isfull[r_sel]) begin
            r_state  <= ST_IDLE;
            r_chosen <= '0;
            r_sel    <= '0;
            r_valid  <= 1'b0;
          end else if (out_ready) begin
            r_state  <= ST_IDLE;
            r_clear  <= r_chosen;
            r_ptr    <= w_ptr_next;
            r_chosen <= '0;
            r_sel    <= '0;
            r_valid  <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state  <= ST_IDLE;
            r_tmo    <= 1'b1;
            r_ptr    <= w_ptr_next;
            r_chosen <= '0;
            r_sel    <= '0;
            r_valid  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_chosen <= '0;
          r_sel    <= '0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign chosen_one  = r_chosen;
  assign read_en     = r_read_en;
  assign clearflag   = r_clear;
  assign sel         = r_sel;
  assign valid_out   = r_valid;
  assign timeout_err = r_tmo;

endmodule : output_arbiter
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_output_arbiter : scenario tasks plus random run vs a port model  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_output_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int SW  = 2;
  localparam int OW  = 2 * N + SW + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  isfull = '0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  chosen_one;
  logic          read_en;
  logic [N-1:0]  clearflag;
  logic [SW-1:0] sel;
  logic          valid_out;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which port holds the link, how long it has held it, and the pulses.
  int m_ptr, m_port, m_age, m_clear;
  bit m_tmo;

  wire [OW-1:0] obs = {chosen_one, read_en, clearflag, sel, valid_out, timeout_err};

  output_arbiter #(.N_PORTS(N), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .isfull      (isfull),
    .out_ready   (out_ready),
    .chosen_one  (chosen_one),
    .read_en     (read_en),
    .clearflag   (clearflag),
    .sel         (sel),
    .valid_out   (valid_out),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required end earlier", $time);
    $fatal(1);
  end

  function automatic logic [OW-1:0] exp_vec();
    logic [N-1:0]  ch, cl;
    logic [SW-1:0] s;
    ch = (m_port >= 0) ? (N'(1) << m_port) : '0;
    cl = (m_clear >= 0) ? (N'(1) << m_clear) : '0;
    s  = (m_port >= 0) ? SW'(m_port) : '0;
    return {ch, (m_port >= 0 && m_age == 0), cl, s, (m_port >= 0 && m_age >= 1), m_tmo};
  endfunction

  task automatic mreset();
    m_ptr = 0; m_port = -1; m_age = 0; m_clear = -1; m_tmo = 0;
  endtask

  // m_age: 0 = grant cycle, k>=1 = k-th cycle spent waiting on out_ready.
  task automatic mstep(input logic [N-1:0] f, input logic r);
    m_clear = -1;
    m_tmo   = 0;
    if (m_port < 0) begin
      for (int k = 0; k < N; k++)
        if (m_port < 0 && f[(m_ptr + k) % N]) begin m_port = (m_ptr + k) % N; m_age = 0; end
    end else if (!f[m_port]) m_port = -1;
    else if (m_age == 0) m_age = 1;
    else if (r) begin m_clear = m_port; m_ptr = (m_port + 1) % N; m_port = -1; end
    else if (m_age == TMO) begin m_tmo = 1; m_ptr = (m_port + 1) % N; m_port = -1; end
    else m_age++;
  endtask

  task automatic cyc(input logic [N-1:0] f, input logic r);
    isfull = f; out_ready = r;
    @(posedge clk);
    if (reset) mreset(); else mstep(f, r);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mreset();
    cyc('0, 1'b0); cyc('0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mreset();
    for (int c = 0; c < 3; c++) begin
      cyc(4'b1111, 1'b1);
      n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs obs=%b required=0", obs); end
    end
    reset = 1'b0;
    cyc(4'b1111, 1'b0);
    n_cmp++; if (chosen_one !== 4'b0001) begin n_bad++; $display("FAIL reset_first_prio chosen=%b required=0001", chosen_one); end
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_model obs=%b required=%b", obs, exp_vec()); end
  endtask

  task automatic test_single_and_wrap();
    do_reset();
    cyc(4'b0100, 1'b1);
    n_cmp++; if ({chosen_one, read_en, sel} !== {4'b0100, 1'b1, 2'd2}) begin n_bad++; $display("FAIL single_grant chosen=%b rd=%b sel=%0d required 0100/1/2", chosen_one, read_en, sel); end
    cyc(4'b0100, 1'b1);
    n_cmp++; if ({valid_out, read_en} !== 2'b10) begin n_bad++; $display("FAIL single_send valid=%b rd=%b required 1/0", valid_out, read_en); end
    cyc(4'b0100, 1'b1);
    n_cmp++; if ({clearflag, valid_out} !== {4'b0100, 1'b0}) begin n_bad++; $display("FAIL single_clear clear=%b valid=%b required 0100/0", clearflag, valid_out); end
    cyc(4'b0000, 1'b1);
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL single_idle obs=%b required=0", obs); end
    for (int c = 0; c < 4; c++) begin
      cyc(4'b1001, 1'b1);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL wrap_model c=%0d obs=%b required=%b", c, obs, exp_vec()); end
      if (c == 0) begin
        n_cmp++; if (chosen_one !== 4'b1000) begin n_bad++; $display("FAIL wrap_port3 chosen=%b required=1000", chosen_one); end
      end
      if (c == 3) begin
        n_cmp++; if (chosen_one !== 4'b0001) begin n_bad++; $display("FAIL wrap_port0 chosen=%b required=0001", chosen_one); end
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int clr_cnt[N];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int exp_clr[N] = '{2, 1, 1, 1};
    do_reset();
    for (int k = 0; k < N; k++) clr_cnt[k] = 0;
    for (int c = 0; c < 15; c++) begin
      cyc(4'b1111, 1'b1);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL rr_model c=%0d obs=%b required=%b", c, obs, exp_vec()); end
      if (read_en) for (int k = 0; k < N; k++) if (chosen_one[k]) order.push_back(k);
      for (int k = 0; k < N; k++) if (clearflag[k]) clr_cnt[k]++;
    end
    n_cmp++;
    if (order.size() != 5) begin n_bad++; $display("FAIL rr_count grants=%0d required=5", order.size()); end
    else foreach (exp_order[i]) if (order[i] != exp_order[i]) begin n_bad++; $display("FAIL rr_order idx=%0d port=%0d required=%0d", i, order[i], exp_order[i]); break; end
    n_cmp++;
    foreach (exp_clr[k]) if (clr_cnt[k] != exp_clr[k]) begin n_bad++; $display("FAIL rr_clears port=%0d count=%0d required=%0d", k, clr_cnt[k], exp_clr[k]); break; end
  endtask

  task automatic test_timeout();
    int tmo_at = -1, vcnt = 0, n_clr = 0;
    do_reset();
    for (int c = 0; c < 40 && tmo_at < 0; c++) begin
      cyc(4'b0010, 1'b0);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL tmo_model c=%0d obs=%b required=%b", c, obs, exp_vec()); end
      if (valid_out) vcnt++;
      if (clearflag != 0) n_clr++;
      if (timeout_err) tmo_at = c;
    end
    n_cmp++; if (tmo_at != 16) begin n_bad++; $display("FAIL tmo_cycle at=%0d required=16", tmo_at); end
    n_cmp++; if ({vcnt, n_clr} != {32'd15, 32'd0}) begin n_bad++; $display("FAIL tmo_send_cycles valid=%0d clears=%0d required 15/0", vcnt, n_clr); end
    cyc(4'b1111, 1'b0);
    n_cmp++; if ({chosen_one, timeout_err} !== {4'b0100, 1'b0}) begin n_bad++; $display("FAIL tmo_ptr chosen=%b tmo=%b required 0100/0", chosen_one, timeout_err); end
  endtask

  task automatic test_timeout_tie();
    do_reset();
    for (int c = 0; c < 16; c++) cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b1);
    n_cmp++; if ({clearflag, timeout_err} !== {4'b0001, 1'b0}) begin n_bad++; $display("FAIL tie_transfer clear=%b tmo=%b required 0001/0", clearflag, timeout_err); end
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL tie_model obs=%b required=%b", obs, exp_vec()); end
  endtask

  task automatic test_abort();
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0100, 1'b0);
    cyc(4'b0000, 1'b1);
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL abort_idle obs=%b required=0", obs); end
    cyc(4'b1111, 1'b0);
    n_cmp++; if (chosen_one !== 4'b0001) begin n_bad++; $display("FAIL abort_ptr chosen=%b required=0001", chosen_one); end
    n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL abort_model obs=%b required=%b", obs, exp_vec()); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0010, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL async_reset obs=%b required=0", obs); end
    mreset();
    cyc(4'b0011, 1'b0); cyc(4'b0011, 1'b0);
    reset = 1'b0;
    cyc(4'b0011, 1'b0);
    n_cmp++; if (chosen_one !== 4'b0001) begin n_bad++; $display("FAIL reset_regrant chosen=%b required=0001", chosen_one); end
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    logic         r;
    do_reset();
    f = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) f = N'($urandom);
      r = ((c / 150) % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc(f, r);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL rand_model c=%0d obs=%b required=%b", c, obs, exp_vec()); end
      n_cmp++; if ($countones(chosen_one) > 1 || $countones(clearflag) > 1) begin n_bad++; $display("FAIL rand_onehot chosen=%b clear=%b required at most one bit", chosen_one, clearflag); end
    end
    reset = 1'b0;
  endtask

  initial begin
    mreset();
    test_reset();
    test_single_and_wrap();
    test_round_robin();
    test_timeout();
    test_timeout_tie();
    test_abort();
    test_reset_mid_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_output_arbiter
`default_nettype wire
